// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, baud divider helper, data width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   // Data bits per frame (8N1 / 8E1).
   localparam int DATA_BITS = 8;

   // Transmitter FSM states. PARITY is only reachable when the parity
   // option is compiled into uart_tx_buf.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Clock cycles per line bit (integer division, truncating).
   function automatic int bps_cnt(input int clk_freq, input int uart_bps);
      return clk_freq / uart_bps;
   endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Byte stream into the buffered UART transmitter (valid/ready handshake).
// Latency: n/a (wires only).
// Backpressure: tx_ready low means the byte is not taken on that edge.
//
// Signals:
//   tx_data  - byte to send
//   tx_valid - tx_data is valid
//   tx_ready - transmitter can accept a byte this cycle
interface uart_tx_buf_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   // Producer side.
   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   // Transmitter side.
   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with level count and synchronous reset.
// Latency: a write is visible on rd_data/empty the cycle after its edge.
// Backpressure: writes while full are dropped, even when a read happens on the same edge.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data    - write strobe and data
//   rd_en, rd_data    - read strobe; rd_data shows the head entry
//   full, empty, level- occupancy status
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             wr_ok, rd_ok;

   always_comb begin
      wr_ok    = wr_en && (level_q != DEPTH_L);
      rd_ok    = rd_en && (level_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // DEPTH is a power of two, so the pointers wrap on natural overflow.
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = (level_q == DEPTH_L);
   assign empty   = (level_q == '0);
   assign level   = level_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: queues bytes in a FIFO and sends them as 8N1 (or 8E1) frames.
// Latency: byte written at edge N into an idle, empty buffer is popped at N+1; uart_txd falls at N+2.
// Backpressure: tx_ready = !full (and low during reset); back-to-back frames have no idle gap.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset (aborts frame, drops queued bytes)
//   tx_if      - byte stream in (tx_data / tx_valid / tx_ready)
//   uart_txd   - registered serial line, idle high
//   tx_busy    - frame in progress or bytes queued
//   fifo_level - bytes currently queued
// Build option: define UART_TX_PARITY_EN to add an even parity bit after the data bits.
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int UART_BPS   = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   uart_tx_buf_if.slave                tx_if,
   output logic                        uart_txd,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int BPS = bps_cnt(CLK_FREQ, UART_BPS);
   localparam int CW  = (BPS > 1) ? $clog2(BPS) : 1;

   tx_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic       txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
   logic       parity_q, parity_d;
`endif

   logic       fifo_full, fifo_empty, fifo_rd, push;
   logic [7:0] fifo_rd_data;
   logic       bit_done;
   logic [CW-1:0] cnt_next;

   // Reset also blocks writes so nothing lands in a FIFO that is being cleared.
   assign tx_if.tx_ready = !fifo_full && !rst;
   assign push           = tx_if.tx_valid && tx_if.tx_ready;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (tx_if.tx_data),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign bit_done = (cnt_q == CW'(BPS - 1));
   assign cnt_next = bit_done ? '0 : cnt_q + CW'(1);

   // txd_d is decoded from the current state, so the line trails the FSM by
   // one cycle uniformly; bit lengths and zero-gap chaining are preserved.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_next;
      idx_d   = idx_q;
      shift_d = shift_q;
      txd_d   = 1'b1;
      fifo_rd = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               fifo_rd = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            txd_d = 1'b0;
            if (bit_done) begin
               idx_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            txd_d = shift_q[0];
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            txd_d = parity_q;
            if (bit_done) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            txd_d = 1'b1;
            if (bit_done) begin
               // Chain straight into the next frame when data is waiting.
               if (!fifo_empty) begin
                  fifo_rd = 1'b1;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (fifo_rd) begin
         shift_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
         parity_d = ^fifo_rd_data;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign uart_txd = txd_q;
   assign tx_busy  = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: line waveform, FIFO behaviour, reset, parity option.
// Latency: n/a.
// Backpressure: the bench honours tx_ready and records only accepted bytes.
module tb_uart_tx_buf;

   localparam int BPS  = 10;    // 1 MHz / 100 kbaud
   localparam int BPS2 = 434;   // 50 MHz / 115200
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_buf_if if1();
   uart_tx_buf_if if2();

   logic       txd1, busy1;
   logic [2:0] lvl1;
   logic       txd2, busy2;
   logic [4:0] lvl2;

   uart_tx_buf #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .tx_if(if1.slave),
      .uart_txd(txd1), .tx_busy(busy1), .fifo_level(lvl1));

   uart_tx_buf #(.CLK_FREQ(50_000_000), .UART_BPS(115200), .FIFO_DEPTH(16)) dut2 (
      .clk(clk), .rst(rst), .tx_if(if2.slave),
      .uart_txd(txd2), .tx_busy(busy2), .fifo_level(lvl2));

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];

   // Line monitor for dut: decodes frames by mid-bit sampling.
   logic [7:0] rx_q[$];
   int         rx_t[$];
   logic       rx_par[$];
   logic       rx_stop[$];
   bit         mon_busy = 1'b0;
   logic [7:0] m_d;
   logic       m_p, m_s;
   int         m_t0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && txd1 === 1'b0) begin
            mon_busy = 1'b1;
            m_t0 = cyc;
            repeat (BPS/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BPS) @(negedge clk);
               m_d[i] = txd1;
            end
`ifdef UART_TX_PARITY_EN
            repeat (BPS) @(negedge clk);
            m_p = txd1;
`else
            m_p = 1'b0;
`endif
            repeat (BPS) @(negedge clk);
            m_s = txd1;
            rx_q.push_back(m_d);
            rx_t.push_back(m_t0);
            rx_par.push_back(m_p);
            rx_stop.push_back(m_s);
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Expected line level for bit i of a frame carrying d.
   function automatic logic frame_bit(input logic [7:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return d[i-1];
`ifdef UART_TX_PARITY_EN
      if (i == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      rx_q.delete(); rx_t.delete(); rx_par.delete(); rx_stop.delete();
      exp_q.delete();
   endtask

   task automatic wait_idle(input int max_cyc);
      bit done = 1'b0;
      for (int c = 0; c < max_cyc && !done; c++) begin
         step();
         if (busy1 === 1'b0 && !mon_busy) done = 1'b1;
      end
      repeat (3) step();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles (busy=%b mon=%b)", max_cyc, busy1, mon_busy);
      end
   endtask

   task automatic test_reset();
      if1.tx_valid = 1'b0; if1.tx_data = 8'h00;
      if2.tx_valid = 1'b0; if2.tx_data = 8'h00;
      rst = 1'b1;
      repeat (3) step();
      checks++; if (txd1 !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd1); end
      checks++; if (lvl1 !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", lvl1); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
      checks++; if (if1.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %b want 0", if1.tx_ready); end
      checks++; if (txd2 !== 1'b1 || lvl2 !== 5'd0) begin errors++; $display("FAIL reset_dut2: txd=%b lvl=%0d want 1/0", txd2, lvl2); end
      rst = 1'b0;
      step();
      checks++; if (if1.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", if1.tx_ready); end
      checks++; if (txd1 !== 1'b1) begin errors++; $display("FAIL reset_txd_after: got %b want 1", txd1); end
   endtask

   task automatic test_single_byte();
      logic e;
      clear_mon();
      if1.tx_data = 8'hA5; if1.tx_valid = 1'b1;
      step();
      if1.tx_valid = 1'b0;
      checks++; if (lvl1 !== 3'd1 || busy1 !== 1'b1) begin errors++; $display("FAIL single_after_write: lvl=%0d busy=%b want 1/1", lvl1, busy1); end
      for (int k = 1; k <= 2 + NB*BPS + 4; k++) begin
         step();
         if (k < 2 || k >= 2 + NB*BPS) e = 1'b1;
         else e = frame_bit(8'hA5, (k-2)/BPS);
         if (k == 1 || k == 2 + NB*BPS + 4 ||
             (k >= 2 && k < 2 + NB*BPS && ((k-2)%BPS == 0 || (k-2)%BPS == BPS-1))) begin
            checks++;
            if (txd1 !== e) begin errors++; $display("FAIL single_line k=%0d: got %b want %b", k, txd1, e); end
         end
         if (k == 1) begin
            checks++; if (lvl1 !== 3'd0) begin errors++; $display("FAIL single_pop: lvl=%0d want 0", lvl1); end
         end
         if (k == NB*BPS) begin
            checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy_hi: got %b want 1", busy1); end
         end
         if (k == 2 + NB*BPS) begin
            checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL single_busy_lo: got %b want 0", busy1); end
         end
      end
      wait_idle(200);
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
         errors++; $display("FAIL single_decode: got %0d frames first=%h want 1 frame a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b [3];
      logic [2:0] lv [3];
      int n0;
      b[0] = 8'h00; b[1] = 8'hFF; b[2] = 8'h55;
      lv[0] = 3'd1; lv[1] = 3'd1; lv[2] = 3'd2;
      clear_mon();
      for (int i = 0; i < 3; i++) begin
         if1.tx_data = b[i]; if1.tx_valid = 1'b1;
         step();
         if (i == 0) n0 = cyc;
         checks++; if (lvl1 !== lv[i]) begin errors++; $display("FAIL burst_level_w%0d: got %0d want %0d", i, lvl1, lv[i]); end
      end
      if1.tx_valid = 1'b0;
      while (cyc < n0 + 2*NB*BPS + 1) begin
         step();
         if (cyc == n0 + NB*BPS) begin
            checks++; if (lvl1 !== 3'd2) begin errors++; $display("FAIL burst_level_pre_pop2: got %0d want 2", lvl1); end
         end
         if (cyc == n0 + 1 + NB*BPS) begin
            checks++; if (lvl1 !== 3'd1) begin errors++; $display("FAIL burst_level_pop2: got %0d want 1", lvl1); end
         end
      end
      checks++; if (lvl1 !== 3'd0) begin errors++; $display("FAIL burst_level_pop3: got %0d want 0", lvl1); end
      wait_idle(500);
      checks++;
      if (rx_q.size() != 3) begin
         errors++; $display("FAIL burst_count: got %0d frames want 3", rx_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (rx_q[i] !== b[i]) begin errors++; $display("FAIL burst_data%0d: got %h want %h", i, rx_q[i], b[i]); end
         end
         checks++; if (rx_t[0] != n0 + 2) begin errors++; $display("FAIL burst_first_start: got %0d want %0d", rx_t[0], n0 + 2); end
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (rx_t[i] - rx_t[i-1] != NB*BPS) begin errors++; $display("FAIL burst_gap%0d: got %0d want %0d", i, rx_t[i] - rx_t[i-1], NB*BPS); end
         end
      end
   endtask

   task automatic test_full_fifo();
      logic [7:0] b [6];
      int idx = 0;
      int bad = 0;
      bit saw_full = 1'b0;
      logic rdy;
      clear_mon();
      for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
      for (int c = 0; c < 2000 && idx < 6; c++) begin
         if1.tx_data = b[idx]; if1.tx_valid = 1'b1;
         #1;
         rdy = if1.tx_ready;
         if (rdy !== (lvl1 != 3'd4)) bad++;
         if (lvl1 == 3'd4 && rdy === 1'b0) saw_full = 1'b1;
         step();
         if (rdy === 1'b1) begin exp_q.push_back(b[idx]); idx++; end
      end
      if1.tx_valid = 1'b0;
      checks++; if (idx != 6) begin errors++; $display("FAIL full_accepted: got %0d want 6", idx); end
      checks++; if (bad != 0) begin errors++; $display("FAIL full_ready_vs_level: %0d cycles where ready != (level<4)", bad); end
      checks++; if (!saw_full) begin errors++; $display("FAIL full_reached: got 0 want 1 (level 4 with ready low)"); end
      wait_idle(1500);
      checks++;
      if (rx_q.size() != exp_q.size()) begin
         errors++; $display("FAIL full_count: got %0d frames want %0d", rx_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_data%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int n0;
      int bad = 0;
      clear_mon();
      for (int i = 0; i < 3; i++) begin
         if1.tx_data = 8'($urandom); if1.tx_valid = 1'b1;
         step();
         if (i == 0) n0 = cyc;
      end
      if1.tx_valid = 1'b0;
      checks++; if (lvl1 !== 3'd2) begin errors++; $display("FAIL rstmid_queued: got %0d want 2", lvl1); end
      // Middle of data bit 3 (line bit 4 counting the start bit).
      while (cyc < n0 + 2 + 4*BPS + BPS/2) step();
      rst = 1'b1;
      #1;
      checks++; if (if1.tx_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_reset: got %b want 0", if1.tx_ready); end
      step();
      rst = 1'b0;
      checks++; if (txd1 !== 1'b1) begin errors++; $display("FAIL rstmid_txd: got %b want 1", txd1); end
      checks++; if (lvl1 !== 3'd0) begin errors++; $display("FAIL rstmid_level: got %0d want 0", lvl1); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy1); end
      for (int k = 0; k < 3*NB*BPS; k++) begin
         step();
         if (txd1 !== 1'b1 || lvl1 !== 3'd0 || busy1 !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: %0d cycles of activity after reset, want 0", bad); end
      wait_idle(200);
   endtask

   task automatic test_parity();
      logic [7:0] b [2];
      b[0] = 8'h07; b[1] = 8'h03;
      clear_mon();
      for (int i = 0; i < 2; i++) begin
         if1.tx_data = b[i]; if1.tx_valid = 1'b1;
         step();
      end
      if1.tx_valid = 1'b0;
      wait_idle(500);
      checks++;
      if (rx_q.size() != 2) begin
         errors++; $display("FAIL parity_count: got %0d frames want 2", rx_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++; if (rx_q[i] !== b[i]) begin errors++; $display("FAIL parity_data%0d: got %h want %h", i, rx_q[i], b[i]); end
            checks++; if (rx_stop[i] !== 1'b1) begin errors++; $display("FAIL parity_stop%0d: got %b want 1", i, rx_stop[i]); end
`ifdef UART_TX_PARITY_EN
            checks++; if (rx_par[i] !== ^b[i]) begin errors++; $display("FAIL parity_bit%0d: got %b want %b", i, rx_par[i], ^b[i]); end
`endif
         end
         checks++;
         if (rx_t[1] - rx_t[0] != NB*BPS) begin errors++; $display("FAIL parity_frame_len: got %0d want %0d", rx_t[1] - rx_t[0], NB*BPS); end
      end
   endtask

   task automatic test_random();
      int sent = 0;
      logic v, rdy;
      logic [7:0] d;
      clear_mon();
      for (int c = 0; c < 4000 && sent < 16; c++) begin
         v = ($urandom_range(0, 1) == 1);
         d = 8'($urandom);
         if1.tx_valid = v; if1.tx_data = d;
         #1;
         rdy = if1.tx_ready;
         step();
         if (v && rdy === 1'b1) begin exp_q.push_back(d); sent++; end
      end
      if1.tx_valid = 1'b0;
      checks++; if (sent != 16) begin errors++; $display("FAIL random_sent: got %0d want 16", sent); end
      wait_idle(2000);
      checks++;
      if (rx_q.size() != exp_q.size()) begin
         errors++; $display("FAIL random_count: got %0d frames want %0d", rx_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i] || rx_stop[i] !== 1'b1) begin
               errors++; $display("FAIL random_data%0d: got %h stop=%b want %h stop=1", i, rx_q[i], rx_stop[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_default_rate();
      logic [7:0] dec = 8'h00;
      logic stp = 1'b0;
      int j;
      if2.tx_data = 8'h3C; if2.tx_valid = 1'b1;
      step();
      if2.tx_valid = 1'b0;
      for (int k = 1; k <= 2 + NB*BPS2 + 2; k++) begin
         step();
         if (k == 1) begin
            checks++; if (txd2 !== 1'b1) begin errors++; $display("FAIL rate_pre_start: got %b want 1", txd2); end
         end
         if (k == 2) begin
            checks++; if (txd2 !== 1'b0) begin errors++; $display("FAIL rate_start: got %b want 0", txd2); end
         end
         if (k >= 2 && k < 2 + NB*BPS2 && (k-2)%BPS2 == BPS2/2) begin
            j = (k-2)/BPS2;
            if (j >= 1 && j <= 8) dec[j-1] = txd2;
            if (j == NB-1) stp = txd2;
         end
         // 0x3C ends in a 0 data/parity bit, so the stop bit edge shows the frame length.
         if (k == 2 + (NB-1)*BPS2 - 1) begin
            checks++; if (txd2 !== 1'b0) begin errors++; $display("FAIL rate_last_bit: got %b want 0", txd2); end
         end
         if (k == 2 + (NB-1)*BPS2) begin
            checks++; if (txd2 !== 1'b1) begin errors++; $display("FAIL rate_stop_edge: got %b want 1", txd2); end
         end
         if (k == 2 + NB*BPS2) begin
            checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rate_busy_end: got %b want 0", busy2); end
         end
      end
      checks++; if (dec !== 8'h3C) begin errors++; $display("FAIL rate_decode: got %h want 3c", dec); end
      checks++; if (stp !== 1'b1) begin errors++; $display("FAIL rate_stop: got %b want 1", stp); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_full_fifo();
      test_reset_mid_frame();
      test_parity();
      test_random();
      test_default_rate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
